// File: rtl/imem_access_ctrl_if.sv
// Instruction-memory access bundle: fetch port, loader port and memory bus.
// The controller takes the slave view; the environment drives the master view.
`timescale 1ns/1ps
interface imem_access_ctrl_if;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        redirect;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        pc_write;
    logic        if_id_write;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_done;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  fetch_req, fetch_addr, redirect,
        input  ld_req, ld_addr, ld_wdata, mem_rdata,
        output fetch_valid, fetch_instr, pc_write, if_id_write,
        output ld_done, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output fetch_req, fetch_addr, redirect,
        output ld_req, ld_addr, ld_wdata, mem_rdata,
        input  fetch_valid, fetch_instr, pc_write, if_id_write,
        input  ld_done, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_access_ctrl.sv
// Arbitrates the single-ported instruction memory between fetch and loader
// and sequences each multi-cycle access; redirects kill in-flight fetches.
`timescale 1ns/1ps
module imem_access_ctrl #(
    parameter int MEM_LATENCY      = 2,
    parameter int LOADER_MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    imem_access_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        RWAIT = 3'd2,
        CAPT  = 3'd3,
        WDONE = 3'd4
    } state_t;

    localparam logic [3:0] LAT_M1    = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] MAX_BURST = 4'(LOADER_MAX_BURST);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_lat
        $error("MEM_LATENCY out of range 1..15");
    end
    if (LOADER_MAX_BURST < 1 || LOADER_MAX_BURST > 15) begin : g_bad_burst
        $error("LOADER_MAX_BURST out of range 1..15");
    end

    state_t      state;
    state_t      state_nxt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] instr_q;
    logic        wr_q;
    logic        kill_q;
    logic        valid_q;
    logic [3:0]  cnt_q;
    logic [3:0]  burst_q;
    logic        fetch_ok;
    logic        grant_f;
    logic        grant_l;
    logic        capt_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The fetch_valid cycle still sees the old PC on fetch_addr, so fetch
    // is not eligible there; the loader may still be granted.
    always_comb begin
        state_nxt = state;
        grant_f   = 1'b0;
        grant_l   = 1'b0;
        fetch_ok  = bus.fetch_req & ~bus.redirect & ~valid_q;
        unique case (state)
            IDLE: begin
                if (fetch_ok && (!bus.ld_req || burst_q >= MAX_BURST)) begin
                    grant_f = 1'b1;
                end else if (bus.ld_req) begin
                    grant_l = 1'b1;
                end
                if (grant_f || grant_l) begin
                    state_nxt = CMD;
                end
            end
            CMD: begin
                if (wr_q) begin
                    state_nxt = WDONE;
                end else if (MEM_LATENCY == 1) begin
                    state_nxt = CAPT;
                end else begin
                    state_nxt = RWAIT;
                end
            end
            RWAIT: begin
                if (cnt_q == 4'd1) begin
                    state_nxt = CAPT;
                end
            end
            CAPT:    state_nxt = IDLE;
            WDONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign capt_ok = (state == CAPT) & ~kill_q & ~bus.redirect;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            burst_q <= '0;
            kill_q  <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= '0;
        end else begin
            if (grant_l) begin
                addr_q  <= bus.ld_addr;
                wdata_q <= bus.ld_wdata;
                wr_q    <= 1'b1;
            end else if (grant_f) begin
                addr_q  <= bus.fetch_addr;
                wdata_q <= '0;
                wr_q    <= 1'b0;
            end

            if (state == IDLE) begin
                if (grant_f || !bus.fetch_req) begin
                    burst_q <= '0;
                end else if (grant_l && burst_q != 4'hF) begin
                    burst_q <= burst_q + 4'd1;
                end
            end

            if (state == CMD) begin
                cnt_q <= LAT_M1;
            end else if (state == RWAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end

            // A killed fetch still runs its memory timing to completion.
            if (state == IDLE || state == CAPT || state == WDONE) begin
                kill_q <= 1'b0;
            end else if (!wr_q && bus.redirect) begin
                kill_q <= 1'b1;
            end

            valid_q <= capt_ok;
            if (capt_ok) begin
                instr_q <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        bus.mem_en      = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.ld_done     = 1'b0;
        unique case (state)
            CMD: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = wr_q;
                bus.mem_addr  = {addr_q[31:2], 2'b00};
                bus.mem_wdata = wdata_q;
            end
            WDONE:   bus.ld_done = 1'b1;
            default: ;
        endcase
        bus.fetch_valid = valid_q;
        bus.if_id_write = valid_q;
        bus.pc_write    = valid_q | bus.redirect;
        bus.fetch_instr = instr_q;
    end
endmodule
